// File: rtl/mult_sched_pkg.sv
// Shared definitions for the multiplier-sharing scheduler family.
// Provides the scheduler state encoding, the default operand width and a
// clog2 helper used to size the latency counter.
package mult_sched_pkg;

  localparam int unsigned DEF_WIDTH = 512;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } sched_state_e;

  // Smallest r with 2**r >= v, never less than 1 so a counter always has a bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    longint unsigned x;
    r = 0;
    x = 1;
    while (x < longint'(v)) begin
      x = x << 1;
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
// Ports:
//   valid0, valid1 : request present on each input
//   prio           : which input wins when both are valid (0 or 1)
//   grant0, grant1 : one-hot (or zero) grant
module rr_pick2 (
  input  logic valid0,
  input  logic valid1,
  input  logic prio,
  output logic grant0,
  output logic grant1
);

  always_comb begin
    grant0 = valid0 & (~valid1 | ~prio);
    grant1 = valid1 & (~valid0 |  prio);
  end

endmodule

// File: rtl/mult_share_sched.sv
// Two-requester scheduler in front of one constant-time multiplier.
// Arbitrates round-robin, launches one multiplication at a time, returns the
// product to the owning requester and flags any completion whose latency
// differs from EXPECTED_LAT (a data-dependent timing leak).
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   reqN_valid/ready/operands     : request channels N=0,1 (ready is combinational)
//   resp_valid/ready/id/product/err : response channel, held stable in RESP
//   mul_start/multiplier/multiplicand : launch interface to the multiplier
//   mul_product, mul_done         : multiplier result (done may be level or pulse)
//   lat_mismatch, timeout         : sticky flags, cleared only by rst
module mult_share_sched
  import mult_sched_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned EXPECTED_LAT = WIDTH,
  parameter int unsigned TIMEOUT      = 2 * WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_multiplier,
  input  logic [WIDTH-1:0]     req0_multiplicand,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_multiplier,
  input  logic [WIDTH-1:0]     req1_multiplicand,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_id,
  output logic [2*WIDTH-1:0]   resp_product,
  output logic                 resp_err,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_multiplier,
  output logic [WIDTH-1:0]     mul_multiplicand,
  input  logic [2*WIDTH-1:0]   mul_product,
  input  logic                 mul_done,
  output logic                 lat_mismatch,
  output logic                 timeout
);

  localparam int unsigned CW = clog2(TIMEOUT + 1);

  sched_state_e       state_q, state_d;
  logic               prio_q, prio_d;
  logic               id_q, id_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mr_q, mr_d;
  logic [WIDTH-1:0]   md_q, md_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               err_q, err_d;
  logic               lm_q, lm_d;
  logic               to_q, to_d;
  logic               grant0, grant1;

  rr_pick2 u_pick (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .prio   (prio_q),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      mr_q    <= '0;
      md_q    <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
      lm_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      mr_q    <= mr_d;
      md_q    <= md_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
      lm_q    <= lm_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    mr_d    = mr_q;
    md_d    = md_q;
    prod_d  = prod_q;
    err_d   = err_q;
    lm_d    = lm_q;
    to_d    = to_q;
    case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          id_d    = grant1;
          prio_d  = grant0;  // next turn goes to the requester not served now
          mr_d    = grant1 ? req1_multiplier   : req0_multiplier;
          md_d    = grant1 ? req1_multiplicand : req0_multiplicand;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        // mul_done is deliberately ignored here: it may be left over from the previous job.
        cnt_d   = CW'(1);
        state_d = WAIT;
      end
      WAIT: begin
        // Completion takes precedence over a timeout landing on the same edge.
        if (mul_done) begin
          prod_d  = mul_product;
          err_d   = 1'b0;
          if (cnt_q != CW'(EXPECTED_LAT)) lm_d = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          prod_d  = '0;
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready       = (state_q == IDLE) & grant0;
    req1_ready       = (state_q == IDLE) & grant1;
    resp_valid       = (state_q == RESP);
    resp_id          = id_q;
    resp_product     = prod_q;
    resp_err         = err_q;
    mul_start        = (state_q == LAUNCH);
    mul_multiplier   = mr_q;
    mul_multiplicand = md_q;
    lat_mismatch     = lm_q;
    timeout          = to_q;
  end

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed self-checking bench for mult_share_sched (WIDTH=8, EXPECTED_LAT=8,
// TIMEOUT=16) with a behavioural multiplier of programmable latency.
module tb_mult_share_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]  req0_multiplier, req0_multiplicand, req1_multiplier, req1_multiplicand;
  logic        resp_valid, resp_ready, resp_id, resp_err;
  logic [15:0] resp_product;
  logic        mul_start, mul_done;
  logic [7:0]  mul_multiplier, mul_multiplicand;
  logic [15:0] mul_product;
  logic        lat_mismatch, timeout;

  always #5 clk = ~clk;

  mult_share_sched #(
    .WIDTH        (8),
    .EXPECTED_LAT (8),
    .TIMEOUT      (16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req0_valid        (req0_valid),
    .req0_ready        (req0_ready),
    .req0_multiplier   (req0_multiplier),
    .req0_multiplicand (req0_multiplicand),
    .req1_valid        (req1_valid),
    .req1_ready        (req1_ready),
    .req1_multiplier   (req1_multiplier),
    .req1_multiplicand (req1_multiplicand),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_id           (resp_id),
    .resp_product      (resp_product),
    .resp_err          (resp_err),
    .mul_start         (mul_start),
    .mul_multiplier    (mul_multiplier),
    .mul_multiplicand  (mul_multiplicand),
    .mul_product       (mul_product),
    .mul_done          (mul_done),
    .lat_mismatch      (lat_mismatch),
    .timeout           (timeout)
  );

  // Behavioural multiplier: done is seen on the m_lat-th edge after the start edge.
  // m_lat == 0 means it never completes.
  int unsigned m_lat = 8;
  int unsigned m_cnt = 0;
  logic        m_busy = 1'b0;
  logic [15:0] m_prod = '0;
  logic        force_done = 1'b0;
  logic        m_fire;

  assign m_fire      = m_busy && (m_lat != 0) && (m_cnt == m_lat);
  assign mul_done    = m_fire || force_done;
  assign mul_product = m_prod;

  always @(posedge clk) begin
    if (mul_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 1;
      m_prod <= {8'd0, mul_multiplier} * {8'd0, mul_multiplicand};
    end else if (m_busy) begin
      if (m_fire) m_busy <= 1'b0;
      else        m_cnt  <= m_cnt + 1;
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; resp_ready = 0; force_done = 0;
    req0_multiplier = '0; req0_multiplicand = '0;
    req1_multiplier = '0; req1_multiplicand = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One isolated job: accept in cycle 0, then watch for the response.
  task automatic job(input string tag, input bit who, input logic [7:0] a, input logic [7:0] b,
                     input int unsigned lat, input int exp_cyc, input logic [15:0] exp_prod,
                     input bit exp_err);
    int cyc;
    int starts;
    int start_cyc;
    m_lat = lat;
    if (who) begin
      req1_valid = 1; req1_multiplier = a; req1_multiplicand = b;
    end else begin
      req0_valid = 1; req0_multiplier = a; req0_multiplicand = b;
    end
    #1;
    check({tag, ":ready"}, who ? req1_ready : req0_ready, 1);
    check({tag, ":other_ready"}, who ? req0_ready : req1_ready, 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    cyc = 1; starts = 0; start_cyc = -1;
    while (!resp_valid && cyc < 40) begin
      if (mul_start) begin
        starts++;
        start_cyc = cyc;
      end
      tick();
      cyc++;
    end
    check({tag, ":start_cycle"}, start_cyc, 1);
    check({tag, ":start_count"}, starts, 1);
    check({tag, ":resp_cycle"}, cyc, exp_cyc);
    check({tag, ":resp_id"}, resp_id, who);
    check({tag, ":product"}, resp_product, exp_prod);
    check({tag, ":err"}, resp_err, exp_err);
    resp_ready = 1;
    tick();
    resp_ready = 0;
    #1;
    check({tag, ":resp_drop"}, resp_valid, 0);
  endtask

  int g_id[$];
  int g_cyc[$];
  int r_id[$];
  int r_prod[$];

  initial begin
    do_reset();

    // Reset state
    #1;
    check("rst:resp_valid", resp_valid, 0);
    check("rst:mul_start", mul_start, 0);
    check("rst:product", resp_product, 0);
    check("rst:mul_mr", mul_multiplier, 0);
    check("rst:lat_mismatch", lat_mismatch, 0);
    check("rst:timeout", timeout, 0);

    // Single job
    job("single", 0, 8'd13, 8'd11, 8, 10, 16'd143, 0);
    check("single:lat_mismatch", lat_mismatch, 0);

    // Contention: both valid continuously, resp_ready held high
    do_reset();
    m_lat = 8;
    resp_ready = 1;
    req0_valid = 1; req0_multiplier = 8'd3; req0_multiplicand = 8'd5;
    req1_valid = 1; req1_multiplier = 8'd7; req1_multiplicand = 8'd9;
    #1;
    for (int c = 0; c < 33; c++) begin
      if (req0_ready) begin g_id.push_back(0); g_cyc.push_back(c); end
      if (req1_ready) begin g_id.push_back(1); g_cyc.push_back(c); end
      if (resp_valid) begin r_id.push_back(int'(resp_id)); r_prod.push_back(int'(resp_product)); end
      tick();
    end
    req0_valid = 0; req1_valid = 0; resp_ready = 0;
    check("cont:grants", g_id.size(), 3);
    check("cont:resps", r_id.size(), 3);
    if (g_id.size() == 3 && r_id.size() == 3) begin
      check("cont:g0", g_id[0], 0);
      check("cont:g1", g_id[1], 1);
      check("cont:g2", g_id[2], 0);
      check("cont:spacing", g_cyc[1] - g_cyc[0], 11);
      check("cont:p0", r_prod[0], 15);
      check("cont:p1", r_prod[1], 63);
      check("cont:p2", r_prod[2], 15);
      check("cont:id1", r_id[1], 1);
    end

    // Leak: short latency, sticky through a later correct job
    tick();
    job("leak", 0, 8'd255, 8'd255, 6, 8, 16'd65025, 0);
    check("leak:lat_mismatch", lat_mismatch, 1);
    job("after_leak", 1, 8'd2, 8'd3, 8, 10, 16'd6, 0);
    check("after_leak:lat_mismatch", lat_mismatch, 1);
    check("after_leak:timeout", timeout, 0);

    // Done coincident with cnt==TIMEOUT: completion wins
    do_reset();
    job("tie", 0, 8'd3, 8'd3, 16, 18, 16'd9, 0);
    check("tie:timeout", timeout, 0);
    check("tie:lat_mismatch", lat_mismatch, 1);

    // Timeout, then a normal job
    do_reset();
    job("tmo", 1, 8'd9, 8'd9, 0, 18, 16'd0, 1);
    check("tmo:timeout", timeout, 1);
    check("tmo:lat_mismatch", lat_mismatch, 0);
    job("after_tmo", 0, 8'd10, 8'd10, 8, 10, 16'd100, 0);
    check("after_tmo:timeout", timeout, 1);

    // Single-valid req1 after reset, then backpressure
    do_reset();
    m_lat = 8;
    req1_valid = 1; req1_multiplier = 8'd4; req1_multiplicand = 8'd4;
    #1;
    check("bp:req1_ready", req1_ready, 1);
    tick();
    req1_valid = 0;
    for (int c = 0; c < 40 && !resp_valid; c++) tick();
    check("bp:resp_valid", resp_valid, 1);
    req0_valid = 1; req0_multiplier = 8'd1; req0_multiplicand = 8'd1;
    req1_valid = 1;
    #1;
    for (int c = 0; c < 5; c++) begin
      check("bp:hold_valid", resp_valid, 1);
      check("bp:hold_prod", resp_product, 16);
      check("bp:hold_id", resp_id, 1);
      check("bp:ready_low", {req0_ready, req1_ready}, 0);
      check("bp:no_start", mul_start, 0);
      tick();
    end
    resp_ready = 1;
    tick();
    resp_ready = 0;
    #1;
    check("bp:idle_req0_ready", req0_ready, 1);
    check("bp:idle_req1_ready", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;
    #1;

    // Reset mid-WAIT
    do_reset();
    m_lat = 8;
    req0_valid = 1; req0_multiplier = 8'd5; req0_multiplicand = 8'd6;
    tick();
    req0_valid = 0;
    for (int c = 1; c < 5; c++) tick();
    check("midrst:waiting", resp_valid, 0);
    check("midrst:op_loaded", mul_multiplier, 5);
    rst = 1;
    tick();
    rst = 0;
    #1;
    check("midrst:resp_valid", resp_valid, 0);
    check("midrst:mul_start", mul_start, 0);
    check("midrst:mul_mr", mul_multiplier, 0);
    check("midrst:mul_md", mul_multiplicand, 0);
    check("midrst:product", resp_product, 0);
    req0_valid = 1; req1_valid = 1;
    #1;
    check("midrst:prio_req0", req0_ready, 1);
    check("midrst:prio_req1", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;
    tick();
    force_done = 1;
    begin
      int seen_resp;
      int seen_start;
      seen_resp = 0; seen_start = 0;
      for (int c = 0; c < 12; c++) begin
        if (resp_valid) seen_resp++;
        if (mul_start) seen_start++;
        tick();
        force_done = 0;
      end
      check("midrst:no_resp", seen_resp, 0);
      check("midrst:no_start", seen_start, 0);
    end
    check("midrst:lat_mismatch", lat_mismatch, 0);
    check("midrst:timeout", timeout, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mult_share_sched.md
# mult_share_sched

Two-requester scheduler in front of a single constant-time multiplier instance (start / productDone interface). It arbitrates round-robin, launches one multiplication at a time, and returns the product to the owning requester. It checks that every multiplication completes in exactly the expected number of cycles, and flags any data-dependent latency, i.e. a timing leak.

## Interface
- WIDTH, 512, operand width; products are 2*WIDTH
- EXPECTED_LAT, WIDTH, required clock edges from the edge sampling mul_start=1 to the edge sampling mul_done=1
- TIMEOUT, 2*WIDTH, WAIT-cycle limit before the job is abandoned; must be > EXPECTED_LAT
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_multiplier, req0_multiplicand, req1_multiplier, req1_multiplicand  in  WIDTH  operands, sampled on the accept edge
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed
- resp_id  out  1  requester index of the response
- resp_product  out  2*WIDTH  product
- resp_err  out  1  job timed out; resp_product is 0
- mul_start  out  1  one-cycle launch pulse to the multiplier
- mul_multiplier, mul_multiplicand  out  WIDTH  registered operands, held stable from launch to RESP
- mul_product  in  2*WIDTH  multiplier result
- mul_done  in  1  multiplier completion, level or pulse
- lat_mismatch  out  1  sticky; a completion occurred at a latency other than EXPECTED_LAT
- timeout  out  1  sticky; a job hit TIMEOUT

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- **IDLE**
  - grant0 = req0_valid & (~req1_valid | prio==0); grant1 = req1_valid & (~req0_valid | prio==1).
  - reqN_ready = IDLE & grantN. This is combinational and depends on valid.
  - On accept: capture operands into mul_* registers, set id=N, set prio = ~N, go to LAUNCH.
- **LAUNCH**
  - mul_start=1 for exactly this cycle; cnt<=1; go to WAIT.
  - mul_done is ignored here, since it may be stale from the previous job.
- **WAIT**
  - If mul_done: capture mul_product into resp_product, resp_err=0. If cnt != EXPECTED_LAT, set lat_mismatch. Go to RESP.
  - Else if cnt == TIMEOUT: resp_product=0, resp_err=1, set timeout, go to RESP.
  - Else cnt<=cnt+1.
- **RESP**
  - resp_valid=1; resp_id, resp_product and resp_err are held stable.
  - On resp_valid & resp_ready, go to IDLE. No requests are accepted in RESP, even if resp_ready is high.
- Requests arriving outside IDLE wait; requesters must hold valid and operands stable until ready.
- No early-out: a response is never produced before mul_done or the timeout.
- cnt width: clog2(TIMEOUT+1).

## Timing
- Reset values: state=IDLE, prio=0 (req0 first), all outputs 0, both stickies cleared. Reset mid-job aborts it silently, with no response.
- Latency with the accept in cycle 0: LAUNCH is cycle 1, WAIT starts in cycle 2, and resp_valid rises in cycle L+2, where L is the measured latency. For a correct multiplier this is EXPECTED_LAT+2.
- Back-to-back: the earliest next accept is the cycle after the resp handshake.
- Throughput is one job per EXPECTED_LAT+3 cycles when resp_ready is held high.
- If mul_done and cnt==TIMEOUT occur together, the completion wins: no timeout and resp_err=0.
- If both requesters are continuously valid, grants alternate strictly 0,1,0,1...
- Stickies clear only on rst.

## Structure
- Shared header/package mult_sched_pkg:
  - state encoding localparams (IDLE=0, LAUNCH=1, WAIT=2, RESP=3)
  - default WIDTH
  - a clog2 function for cnt sizing
- Sub-module rr_pick2: a combinational two-way round-robin picker (valid0, valid1, prio in; grant0, grant1 out). It is reused by later N-input variants.
- The multiplier is not instantiated here; the integrating top wires mul_* ports to it.

## Test plan
Bench parameters: WIDTH=8, EXPECTED_LAT=8, TIMEOUT=16, with a behavioural multiplier model of programmable latency.
- **Single job:** req0 with 13×11, model latency 8 -> accept in cycle 0, mul_start only in cycle 1, resp_valid in cycle 10, resp_id=0, product=143, lat_mismatch=0.
- **Contention:** req0 and req1 both valid continuously (3×5, 7×9) -> req0 served first (15), then req1 (63), then req0. A single-valid req1 after reset is granted immediately.
- **Leak:** model latency 6 for 255×255 -> product 65025 returned in cycle 8, lat_mismatch rises and stays 1 through later correct jobs.
- **Timeout:** model never asserts done -> resp_valid in cycle 18 with resp_err=1, product 0, timeout=1. The next job proceeds normally.
- **Backpressure:** resp_ready held low for 5 cycles -> resp outputs stable, both ready low, no mul_start. Handshake then returns to IDLE.
- **Reset mid-WAIT:** rst in cycle 5 -> cycle 6 has all outputs 0 and prio=0. A stale mul_done right after is ignored, with no response and no flag.
